// File: rtl/pitch_pkg.sv
// Shared types and default thresholds for the pitch band classifier.
package pitch_pkg;

   typedef enum logic [1:0] {BAND0, BAND1, BAND2, BAND3} band_t;

   typedef enum logic {STABLE, PENDING} cls_state_t;

   localparam int DEF_BIN_W    = 10;
   localparam int DEF_T1       = 20;
   localparam int DEF_T2       = 60;
   localparam int DEF_T3       = 150;
   localparam int DEF_HYST     = 4;
   localparam int DEF_STABLE_N = 3;
   localparam int DEF_BIN_MIN  = 2;

endpackage

// File: rtl/pitch_hyst_quantiser.sv
// Stage 1: hysteretic threshold quantiser with silence gate, one registered cycle.
module pitch_hyst_quantiser
   import pitch_pkg::*;
#(
   parameter int BIN_W   = DEF_BIN_W,
   parameter int T1      = DEF_T1,
   parameter int T2      = DEF_T2,
   parameter int T3      = DEF_T3,
   parameter int HYST    = DEF_HYST,
   parameter int BIN_MIN = DEF_BIN_MIN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BIN_W-1:0] bin_in,
   input  logic             bin_valid,
   input  band_t            band_cur,
   output band_t            raw,
   output logic             raw_valid
);

   localparam int EW = BIN_W + 1;

   // A threshold at or below the current band is lowered, one above it is raised,
   // so the band currently held is always the sticky one.
   localparam logic [EW-1:0] LO1   = EW'(T1 - HYST);
   localparam logic [EW-1:0] HI1   = EW'(T1 + HYST);
   localparam logic [EW-1:0] LO2   = EW'(T2 - HYST);
   localparam logic [EW-1:0] HI2   = EW'(T2 + HYST);
   localparam logic [EW-1:0] LO3   = EW'(T3 - HYST);
   localparam logic [EW-1:0] HI3   = EW'(T3 + HYST);
   localparam logic [EW-1:0] MIN_E = EW'(BIN_MIN);

   logic [EW-1:0] bin_ext;
   logic [EW-1:0] eff1, eff2, eff3;
   logic          ge1, ge2, ge3;
   logic [1:0]    raw_c;
   logic          keep;

   always_comb begin
      bin_ext = {1'b0, bin_in};
      eff1    = (band_cur >= BAND1) ? LO1 : HI1;
      eff2    = (band_cur >= BAND2) ? LO2 : HI2;
      eff3    = (band_cur >= BAND3) ? LO3 : HI3;
      ge1     = (bin_ext >= eff1);
      ge2     = (bin_ext >= eff2);
      ge3     = (bin_ext >= eff3);
      raw_c   = {1'b0, ge1} + {1'b0, ge2} + {1'b0, ge3};
      keep    = bin_valid && (bin_ext >= MIN_E);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         raw       <= BAND0;
         raw_valid <= 1'b0;
      end else begin
         raw_valid <= keep;
         if (keep) begin
            raw <= band_t'(raw_c);
         end
      end
   end

endmodule

// File: rtl/pitch_band_classifier.sv
// Debounced 2-bit frequency band from the dominant FFT bin: hysteretic quantiser
// followed by a STABLE/PENDING confirmation FSM.
module pitch_band_classifier
   import pitch_pkg::*;
#(
   parameter int BIN_W    = DEF_BIN_W,
   parameter int T1       = DEF_T1,
   parameter int T2       = DEF_T2,
   parameter int T3       = DEF_T3,
   parameter int HYST     = DEF_HYST,
   parameter int STABLE_N = DEF_STABLE_N,
   parameter int BIN_MIN  = DEF_BIN_MIN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BIN_W-1:0] bin_in,
   input  logic             bin_valid,
   output logic [1:0]       band_out,
   output logic             band_valid,
   output logic             band_changed
);

   // Handshake: bin_valid is a one-cycle strobe that is always accepted (no ready).
   // Each accepted non-silent bin yields one band_valid pulse two cycles later;
   // band_changed only ever pulses together with band_valid, on the edge band_out moves.

   if (!(STABLE_N >= 1 && BIN_MIN <= T1 - HYST && T1 + HYST < T2 - HYST &&
         T2 + HYST < T3 - HYST && T3 + HYST < (1 << BIN_W))) begin : g_cfg_check
      $error("pitch_band_classifier: illegal threshold configuration");
   end

   localparam int CNT_W = $clog2(STABLE_N + 1);

   band_t             band_q;
   band_t             raw;
   logic              raw_valid;
   band_t             cand;
   logic [CNT_W-1:0]  cnt;
   cls_state_t        state;

   pitch_hyst_quantiser #(
      .BIN_W   (BIN_W),
      .T1      (T1),
      .T2      (T2),
      .T3      (T3),
      .HYST    (HYST),
      .BIN_MIN (BIN_MIN)
   ) u_quant (
      .clk       (clk),
      .reset     (reset),
      .bin_in    (bin_in),
      .bin_valid (bin_valid),
      .band_cur  (band_q),
      .raw       (raw),
      .raw_valid (raw_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= STABLE;
         cand         <= BAND0;
         cnt          <= '0;
         band_q       <= BAND0;
         band_valid   <= 1'b0;
         band_changed <= 1'b0;
      end else begin
         band_valid   <= raw_valid;
         band_changed <= 1'b0;
         if (raw_valid) begin
            case (state)
               STABLE: begin
                  if (raw != band_q) begin
                     if (STABLE_N == 1) begin
                        band_q       <= raw;
                        band_changed <= 1'b1;
                     end else begin
                        cand  <= raw;
                        cnt   <= CNT_W'(1);
                        state <= PENDING;
                     end
                  end
               end
               PENDING: begin
                  if (raw == cand) begin
                     // Commit on the frame that completes the run, so cnt never exceeds STABLE_N.
                     if (int'(cnt) + 1 >= STABLE_N) begin
                        band_q       <= cand;
                        band_changed <= 1'b1;
                        cnt          <= '0;
                        state        <= STABLE;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end else if (raw == band_q) begin
                     cnt   <= '0;
                     state <= STABLE;
                  end else begin
                     cand <= raw;
                     cnt  <= CNT_W'(1);
                  end
               end
               default: state <= STABLE;
            endcase
         end
      end
   end

   assign band_out = band_q;

endmodule

// File: tb/tb_pitch_band_classifier.sv
// Directed and randomized bench for pitch_band_classifier against a frame-level reference model.
module tb_pitch_band_classifier;

   localparam int BIN_W    = 10;
   localparam int T1       = 20;
   localparam int T2       = 60;
   localparam int T3       = 150;
   localparam int HYST     = 4;
   localparam int STABLE_N = 3;
   localparam int BIN_MIN  = 2;
   localparam int GAP      = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [BIN_W-1:0] bin_in = '0;
   logic             bin_valid = 1'b0;
   logic [1:0]       band_out;
   logic             band_valid;
   logic             band_changed;

   int vectors = 0;
   int miscompares = 0;
   int chg_seen = 0;

   // Reference model state: committed band, current disagreeing run, frame in flight.
   int m_band = 0;
   int run_val = 0;
   int run_len = 0;
   bit pend_v = 1'b0;
   int pend_raw = 0;
   int exp_valid = 0;
   int exp_changed = 0;

   pitch_band_classifier #(
      .BIN_W    (BIN_W),
      .T1       (T1),
      .T2       (T2),
      .T3       (T3),
      .HYST     (HYST),
      .STABLE_N (STABLE_N),
      .BIN_MIN  (BIN_MIN)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bin_in       (bin_in),
      .bin_valid    (bin_valid),
      .band_out     (band_out),
      .band_valid   (band_valid),
      .band_changed (band_changed)
   );

   always #5 clk = ~clk;

   // Band a bin falls in, given the band currently held; -1 means silence.
   function automatic int classify(input int b, input int band);
      int thr[3];
      int r;
      thr = '{T1, T2, T3};
      r = 0;
      if (b < BIN_MIN) return -1;
      for (int k = 1; k <= 3; k++) begin
         if (b >= ((k <= band) ? thr[k-1] - HYST : thr[k-1] + HYST)) r++;
      end
      return r;
   endfunction

   // A band change needs STABLE_N consecutive frames agreeing on the same new band;
   // any frame matching the held band breaks the run.
   task automatic debounce(input int raw);
      if (raw == m_band) begin
         run_len = 0;
      end else begin
         if (run_len > 0 && raw == run_val) run_len++;
         else begin
            run_val = raw;
            run_len = 1;
         end
         if (run_len >= STABLE_N) begin
            m_band      = raw;
            run_len     = 0;
            exp_changed = 1;
         end
      end
   endtask

   task automatic model_edge(input int b, input bit v);
      int nraw;
      nraw        = v ? classify(b, m_band) : -1;
      exp_valid   = pend_v;
      exp_changed = 0;
      if (pend_v) debounce(pend_raw);
      pend_v   = (nraw >= 0);
      pend_raw = nraw;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic apply(input int b, input bit v);
      bin_in    = BIN_W'(b);
      bin_valid = v;
      @(posedge clk);
      model_edge(b, v);
      #1;
      check("band_out", 32'(band_out), 32'(m_band));
      check("band_valid", 32'(band_valid), 32'(exp_valid));
      check("band_changed", 32'(band_changed), 32'(exp_changed));
      if (band_changed === 1'b1) chg_seen++;
   endtask

   task automatic frame(input int b);
      apply(b, 1'b1);
      repeat (GAP) apply(0, 1'b0);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      bin_valid = 1'b0;
      @(posedge clk);
      m_band      = 0;
      run_len     = 0;
      pend_v      = 1'b0;
      exp_valid   = 0;
      exp_changed = 0;
      #1;
      reset = 1'b1;
      check("rst_band_out", 32'(band_out), 32'd0);
      check("rst_band_valid", 32'(band_valid), 32'd0);
      check("rst_band_changed", 32'(band_changed), 32'd0);
   endtask

   initial begin
      @(posedge clk);
      do_reset();

      // 1: three spaced 40s commit band 1 with a single change pulse
      chg_seen = 0;
      repeat (3) frame(40);
      check("t1_band", 32'(band_out), 32'd1);
      check("t1_changes", 32'(chg_seen), 32'd1);

      // 2: just below the raised T2 stays in band 1, then 64 moves to band 2
      frame(62); frame(63); frame(62);
      check("t2_hold", 32'(band_out), 32'd1);
      repeat (3) frame(64);
      check("t2_band", 32'(band_out), 32'd2);

      // 3: lowered T2 holds band 2 at 56, 55 drops to band 1
      repeat (4) frame(56);
      check("t3_hold", 32'(band_out), 32'd2);
      chg_seen = 0;
      repeat (3) frame(55);
      check("t3_band", 32'(band_out), 32'd1);
      check("t3_changes", 32'(chg_seen), 32'd1);
      repeat (3) frame(10);
      check("t3_back0", 32'(band_out), 32'd0);

      // 4: candidate switches mid-run, straight to band 2
      chg_seen = 0;
      frame(40); frame(40); frame(100); frame(100); frame(100);
      check("t4_band", 32'(band_out), 32'd2);
      check("t4_changes", 32'(chg_seen), 32'd1);
      repeat (3) frame(10);

      // 5: silence bins are dropped and do not break the run
      frame(40); frame(1); frame(0); frame(40); frame(40);
      check("t5_band", 32'(band_out), 32'd1);
      repeat (3) frame(10);

      // 6: reset discards a partial run
      frame(40); frame(40);
      do_reset();
      frame(40); frame(40);
      check("t6_hold", 32'(band_out), 32'd0);
      frame(40);
      check("t6_band", 32'(band_out), 32'd1);

      // back-to-back frames evaluate against the not-yet-updated band
      repeat (4) apply(100, 1'b1);
      repeat (5) apply(10, 1'b1);
      repeat (3) apply(200, 1'b1);
      repeat (3) apply(0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         int sel;
         int b;
         sel = $urandom_range(0, 9);
         case (sel)
            0:       b = $urandom_range(0, 3);
            1, 2:    b = $urandom_range(14, 26);
            3, 4:    b = $urandom_range(54, 66);
            5, 6:    b = $urandom_range(144, 156);
            default: b = $urandom_range(0, 1023);
         endcase
         if (i == 300) do_reset();
         apply(b, $urandom_range(0, 2) != 0);
      end
      repeat (3) apply(0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
